// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / RV32M block: op encodings, FSM states, defaults.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  // op = {m_ext, alt, funct3}
  localparam logic [4:0] OP_ADD    = 5'b0_0_000;
  localparam logic [4:0] OP_SUB    = 5'b0_1_000;
  localparam logic [4:0] OP_SLL    = 5'b0_0_001;
  localparam logic [4:0] OP_SLT    = 5'b0_0_010;
  localparam logic [4:0] OP_SLTU   = 5'b0_0_011;
  localparam logic [4:0] OP_XOR    = 5'b0_0_100;
  localparam logic [4:0] OP_SRL    = 5'b0_0_101;
  localparam logic [4:0] OP_SRA    = 5'b0_1_101;
  localparam logic [4:0] OP_OR     = 5'b0_0_110;
  localparam logic [4:0] OP_AND    = 5'b0_0_111;
  localparam logic [4:0] OP_MUL    = 5'b1_0_000;
  localparam logic [4:0] OP_MULH   = 5'b1_0_001;
  localparam logic [4:0] OP_MULHSU = 5'b1_0_010;
  localparam logic [4:0] OP_MULHU  = 5'b1_0_011;
  localparam logic [4:0] OP_DIV    = 5'b1_0_100;
  localparam logic [4:0] OP_DIVU   = 5'b1_0_101;
  localparam logic [4:0] OP_REM    = 5'b1_0_110;
  localparam logic [4:0] OP_REMU   = 5'b1_0_111;

  // funct3 views, used where m_ext/alt are already resolved
  localparam logic [2:0] F3_MUL    = OP_MUL[2:0];
  localparam logic [2:0] F3_MULH   = OP_MULH[2:0];
  localparam logic [2:0] F3_MULHSU = OP_MULHSU[2:0];
  localparam logic [2:0] F3_MULHU  = OP_MULHU[2:0];
  localparam logic [2:0] F3_DIV    = OP_DIV[2:0];
  localparam logic [2:0] F3_DIVU   = OP_DIVU[2:0];
  localparam logic [2:0] F3_REM    = OP_REM[2:0];
  localparam logic [2:0] F3_REMU   = OP_REMU[2:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/add_suber.sv
// Adder/subtractor with two's-complement signed overflow detect.
module add_suber #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign sum_o = a_i + b_eff + W'(sub_i);
  // overflow: same-sign effective operands produce a result of the other sign
  assign ovf_o = (a_i[W-1] == b_eff[W-1]) && (sum_o[W-1] != a_i[W-1]);

endmodule

// File: rtl/muldiv_core.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, with sign correction and edge cases resolved in FIX.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              busy_i,
  input  logic [2:0]        f3_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] res_o,
  output logic              ovf_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]          f3_q;
  logic [DATA_W-1:0]   a_q, mb_q, quo_q, rem_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_res_q, neg_rem_q, dz_q, ovf_q;

  // operand sign handling at accept
  logic              sgn_a, sgn_b, a_neg, b_neg;
  logic [DATA_W-1:0] ma_d, mb_d;

  assign sgn_a = (f3_i == F3_MULH) || (f3_i == F3_MULHSU) || (f3_i == F3_DIV) || (f3_i == F3_REM);
  assign sgn_b = (f3_i == F3_MULH) || (f3_i == F3_DIV) || (f3_i == F3_REM);
  assign a_neg = sgn_a & a_i[DATA_W-1];
  assign b_neg = sgn_b & b_i[DATA_W-1];
  assign ma_d  = a_neg ? -a_i : a_i;
  assign mb_d  = b_neg ? -b_i : b_i;

  // one multiply step: conditional add into the upper half, then shift right
  logic [DATA_W:0] madd;
  assign madd = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mb_q} : '0);

  // one divide step: the shifted partial remainder is DATA_W+1 bits; borrow out means "doesn't fit"
  logic [DATA_W:0] rsh, rdiff;
  assign rsh   = {rem_q, quo_q[DATA_W-1]};
  assign rdiff = rsh - {1'b0, mb_q};

  // capture magnitudes on start, then iterate while the FSM is in MUL/DIV
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q <= '0; a_q <= '0; mb_q <= '0; quo_q <= '0; rem_q <= '0; prod_q <= '0;
      cnt_q <= '0; neg_res_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
    end else if (start_i) begin
      f3_q      <= f3_i;
      a_q       <= a_i;
      mb_q      <= mb_d;
      prod_q    <= {{DATA_W{1'b0}}, ma_d};
      quo_q     <= ma_d;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= (b_i == '0);
      ovf_q     <= ((f3_i == F3_DIV) || (f3_i == F3_REM)) && (a_i == MIN_VAL) && (b_i == '1);
    end else if (busy_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (f3_q[2]) begin
        quo_q <= {quo_q[DATA_W-2:0], ~rdiff[DATA_W]};
        rem_q <= rdiff[DATA_W] ? rsh[DATA_W-1:0] : rdiff[DATA_W-1:0];
      end else begin
        prod_q <= {madd, prod_q[DATA_W-1:1]};
      end
    end
  end

  assign last_o = (cnt_q == CNT_LAST);
  assign ovf_o  = ovf_q;

  // FIX: sign correction and divide-by-zero substitution. MIN/-1 needs no
  // special result: |MIN|/1 negated wraps back to MIN with remainder 0.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -quo_q  : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q  : rem_q;

  // result select by funct3
  always_comb begin
    res_o = '0;
    case (f3_q)
      F3_MUL:                       res_o = prod_fix[DATA_W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_o = prod_fix[2*DATA_W-1:DATA_W];
      F3_DIV, F3_DIVU:              res_o = dz_q ? '1 : quo_fix;
      default:                      res_o = dz_q ? a_q : rem_fix;
    endcase
  end

endmodule

// File: rtl/shifter.sv
// Barrel shifter: logical left, logical right or arithmetic right.
module shifter #(
  parameter int W       = 32,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic [W-1:0]       d_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               right_i,
  input  logic               arith_i,
  output logic [W-1:0]       q_o
);

  // select shift direction / fill
  always_comb begin
    if (!right_i)     q_o = d_i << shamt_i;
    else if (arith_i) q_o = W'($signed(d_i) >>> shamt_i);
    else              q_o = d_i >> shamt_i;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked integer ALU: single-cycle base ops, iterative RV32M ops,
// result held in an output register until the consumer takes it.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  state_t state_q, state_d;
  logic   accept, m_ext, alt, busy, core_last, core_ovf;
  logic [2:0] f3;
  logic [DATA_W-1:0] result_q, base_res, as_sum, sh_out, core_res;
  logic zero_q, overflow_q, as_ovf, base_ovf;

  assign m_ext  = op[4];
  assign alt    = op[3];
  assign f3     = op[2:0];
  assign accept = in_valid & in_ready;

  add_suber #(.W(DATA_W)) u_add (
    .a_i(a), .b_i(b), .sub_i(alt), .sum_o(as_sum), .ovf_o(as_ovf)
  );

  shifter #(.W(DATA_W), .SHAMT_W(SHAMT_W)) u_shf (
    .d_i(a), .shamt_i(b[SHAMT_W-1:0]), .right_i(f3 == 3'b101), .arith_i(alt), .q_o(sh_out)
  );

  muldiv_core #(.DATA_W(DATA_W)) u_md (
    .clk(clk), .rst_n(rst_n), .start_i(accept & m_ext), .busy_i(busy), .f3_i(f3),
    .a_i(a), .b_i(b), .last_o(core_last), .res_o(core_res), .ovf_o(core_ovf)
  );

  // base op result straight from the request inputs; alt is only legal on ADD/SRL
  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    case (f3)
      3'b000: begin base_res = as_sum; base_ovf = as_ovf; end
      3'b001: base_res = sh_out;
      3'b010: base_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011: base_res = {{(DATA_W-1){1'b0}}, a < b};
      3'b100: base_res = a ^ b;
      3'b101: base_res = sh_out;
      3'b110: base_res = a | b;
      default: base_res = a & b;
    endcase
    if (alt && (f3 != 3'b000) && (f3 != 3'b101)) base_res = '0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = m_ext ? (f3[2] ? S_DIV : S_MUL) : S_DONE;
      S_MUL,
      S_DIV:  if (core_last) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_MUL) || (state_q == S_DIV);
  end

  // output register: base ops load at accept, M ops load in FIX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      zero_q <= (a == b);
      if (!m_ext) begin
        result_q   <= base_res;
        overflow_q <= base_ovf;
      end
    end else if (state_q == S_FIX) begin
      result_q   <= core_res;
      overflow_q <= core_ovf;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (DATA_W = 32): directed cases plus
// randomized ops against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, overflow;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  int n_chk = 0;
  int n_err = 0;

  alu_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: RISC-V semantics via plain wide arithmetic
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic v);
    logic [63:0] p;
    r = 0; v = 0; p = 0;
    if (!o[4]) begin
      case (o)
        5'b00000: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
        5'b01000: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
        5'b00001: r = x << y[4:0];
        5'b00010: r = ($signed(x) < $signed(y)) ? 1 : 0;
        5'b00011: r = (x < y) ? 1 : 0;
        5'b00100: r = x ^ y;
        5'b00101: r = x >> y[4:0];
        5'b01101: r = $signed(x) >>> y[4:0];
        5'b00110: r = x | y;
        5'b00111: r = x & y;
        default:  r = 0;
      endcase
    end else begin
      case (o[2:0])
        3'd0: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
        3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); r = p[63:32]; end
        3'd2: begin p = longint'($signed(x)) * longint'({32'h0, y}); r = p[63:32]; end
        3'd3: begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; end
        3'd4: if (y == 0) r = 32'hFFFF_FFFF;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; v = 1; end
              else r = $signed(x) / $signed(y);
        3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
        3'd6: if (y == 0) r = x;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 0; v = 1; end
              else r = $signed(x) % $signed(y);
        default: r = (y == 0) ? x : x % y;
      endcase
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  // issue one request, check latency and outputs, stall 'hold' cycles, then drain
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] er;
    logic ev;
    int lat;
    model(o, x, y, er, ev);
    chk({tag, ".in_ready_pre"}, {31'h0, in_ready}, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom); op = 5'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, o[4] ? 34 : 1);
    chk({tag, ".res"}, result, er);
    chk({tag, ".ovf"}, {31'h0, overflow}, {31'h0, ev});
    chk({tag, ".zero"}, {31'h0, zero}, {31'h0, x == y});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    if (hold > 0) chk({tag, ".hold_res"}, result, er);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drain"}, {30'h0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] er;
    logic ev;
    int lat;
    rst_n = 0; in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst.in_ready", {31'h0, in_ready}, 1);
    chk("rst.out_valid", {31'h0, out_valid}, 0);
    chk("rst.result", result, 0);
    chk("rst.zero_ovf", {30'h0, zero, overflow}, 0);

    run_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("sra", 5'b01101, 32'h8000_0000, 32'h24, 1);
    run_op("mulh", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mul", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 5'b10100, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("rem", 5'b10110, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("divu0", 5'b10101, 32'h8000_0000, 32'h0, 0);
    run_op("remu0", 5'b10111, 32'h8000_0000, 32'h0, 0);
    run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("alt_bad", 5'b01110, 32'h1234_5678, 32'h0F0F_0F0F, 0);

    // backpressure: hold DONE for 5 cycles while offering a new request
    model(5'b10100, 32'd100, 32'd7, er, ev);
    op = 5'b10100; a = 32'd100; b = 32'd7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp.lat", lat, 34);
    for (int i = 0; i < 5; i++) begin
      op = 5'b00000; a = 1; b = 2; in_valid = 1;
      @(posedge clk); #1;
      chk("bp.res", result, er);
      chk("bp.hs", {30'h0, in_ready, out_valid}, 32'h1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp.release", {30'h0, in_ready, out_valid}, 32'h2);
    @(posedge clk); #1;
    chk("bp.no_ghost", {31'h0, out_valid}, 0);

    // reset during a divide
    op = 5'b10100; a = 32'd12345; b = 32'd17; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rstmid.hs", {30'h0, in_ready, out_valid}, 32'h2);
    chk("rstmid.result", result, 0);
    run_op("after_rst", 5'b00000, 32'd3, 32'd4, 0);

    // randomized ops
    for (int k = 0; k < 40; k++) begin
      logic [4:0] ro;
      ro = 5'($urandom);
      if ($urandom_range(0, 3) != 0) ro[3] = ro[4] ? ro[3] : 1'b0;
      run_op($sformatf("rnd%0d_op%02h", k, ro), ro, pick(), pick(), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
